// File: rtl/ls_executor_pkg.sv
// ls_executor_pkg: shared definitions for the load/store execution unit.
// Opcode numbering, default widths, FSM state encoding, access-length
// constants and small opcode-decoding helpers.
package ls_executor_pkg;

  // Default widths used by the executor and its sub-modules
  localparam int DEF_OPNUM_W  = 6;
  localparam int DEF_ROB_ID_W = 4;
  localparam int DEF_XLEN     = 32;

  // Memory opcode numbers as issued by the LS buffer
  localparam logic [DEF_OPNUM_W-1:0] OPNUM_LB  = 6'd11;
  localparam logic [DEF_OPNUM_W-1:0] OPNUM_LH  = 6'd12;
  localparam logic [DEF_OPNUM_W-1:0] OPNUM_LW  = 6'd13;
  localparam logic [DEF_OPNUM_W-1:0] OPNUM_LBU = 6'd14;
  localparam logic [DEF_OPNUM_W-1:0] OPNUM_LHU = 6'd15;
  localparam logic [DEF_OPNUM_W-1:0] OPNUM_SB  = 6'd16;
  localparam logic [DEF_OPNUM_W-1:0] OPNUM_SH  = 6'd17;
  localparam logic [DEF_OPNUM_W-1:0] OPNUM_SW  = 6'd18;

  // Byte counts presented to the memory controller
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Executor FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DISCARD = 2'd2
  } ls_state_e;

  // True for any of the five load opcodes
  function automatic logic is_load_op(input logic [DEF_OPNUM_W-1:0] op);
    return (op == OPNUM_LB) || (op == OPNUM_LH) || (op == OPNUM_LW) ||
           (op == OPNUM_LBU) || (op == OPNUM_LHU);
  endfunction

  // True for any of the three store opcodes
  function automatic logic is_store_op(input logic [DEF_OPNUM_W-1:0] op);
    return (op == OPNUM_SB) || (op == OPNUM_SH) || (op == OPNUM_SW);
  endfunction

  // Access width in bytes for a memory opcode
  function automatic logic [2:0] op_length(input logic [DEF_OPNUM_W-1:0] op);
    logic [2:0] len;
    case (op)
      OPNUM_LB, OPNUM_LBU, OPNUM_SB: len = LEN_B;
      OPNUM_LH, OPNUM_LHU, OPNUM_SH: len = LEN_H;
      default:                       len = LEN_W;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ls_executor_load_extend.sv
// ls_load_extend: combinational sign/zero extension of right-aligned raw
// load data according to the load opcode. LW and non-load opcodes pass
// the raw word through unchanged.
module ls_load_extend
  import ls_executor_pkg::*;
#(
  parameter int OPNUM_W = DEF_OPNUM_W,
  parameter int XLEN    = DEF_XLEN
) (
  input  logic [OPNUM_W-1:0] i_opnum,
  input  logic [XLEN-1:0]    i_raw_data,
  output logic [XLEN-1:0]    o_ext_data
);

  // Select the extension rule for the latched load opcode
  always_comb begin
    o_ext_data = i_raw_data;
    case (i_opnum)
      OPNUM_LB:  o_ext_data = {{(XLEN-8){i_raw_data[7]}}, i_raw_data[7:0]};
      OPNUM_LBU: o_ext_data = {{(XLEN-8){1'b0}}, i_raw_data[7:0]};
      OPNUM_LH:  o_ext_data = {{(XLEN-16){i_raw_data[15]}}, i_raw_data[15:0]};
      OPNUM_LHU: o_ext_data = {{(XLEN-16){1'b0}}, i_raw_data[15:0]};
      default:   o_ext_data = i_raw_data;
    endcase
  end

endmodule

// File: rtl/ls_executor.sv
// ls_executor: load/store execution unit behind the LS buffer. Takes one
// memory request at a time, runs the request/finish handshake with the
// memory controller and broadcasts extended load results on the CDB.
// Rollback cancels in-flight loads (result discarded) but never stores.
// Optional build macro LS_EXECUTOR_PERF_EN adds load/store/stall counters.
module ls_executor
  import ls_executor_pkg::*;
#(
  parameter int OPNUM_W  = DEF_OPNUM_W,
  parameter int ROB_ID_W = DEF_ROB_ID_W,
  parameter int XLEN     = DEF_XLEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                enable_sign_from_ls,
  input  logic [OPNUM_W-1:0]  opnum_from_ls,
  input  logic [XLEN-1:0]     address_from_ls,
  input  logic [XLEN-1:0]     store_data_from_ls,
  input  logic [ROB_ID_W-1:0] rob_id_from_ls,
  input  logic                rollback_sign_from_rob,
  output logic                full_sign_to_ls,
  output logic                enable_sign_to_mc,
  output logic                rw_flag_to_mc,
  output logic [XLEN-1:0]     address_to_mc,
  output logic [2:0]          length_to_mc,
  output logic [XLEN-1:0]     store_data_to_mc,
  input  logic                finish_sign_from_mc,
  input  logic [XLEN-1:0]     data_from_mc,
  output logic                valid_sign,
  output logic [ROB_ID_W-1:0] rob_id,
  output logic [XLEN-1:0]     data
`ifdef LS_EXECUTOR_PERF_EN
  ,
  output logic [31:0]         perf_load_cnt,
  output logic [31:0]         perf_store_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  ls_state_e           r_state;
  logic [OPNUM_W-1:0]  r_opnum;
  logic [ROB_ID_W-1:0] r_rob_id;

  logic                w_req_load;
  logic                w_req_store;
  logic                w_accept;
  logic [XLEN-1:0]     w_ext_data;

  // Decode the incoming request; a load arriving with a rollback is dropped
  always_comb begin
    w_req_load  = is_load_op(opnum_from_ls);
    w_req_store = is_store_op(opnum_from_ls);
    w_accept    = enable_sign_from_ls &&
                  (w_req_store || (w_req_load && !rollback_sign_from_rob));
  end

  // Busy whenever a transaction is outstanding
  assign full_sign_to_ls = (r_state != ST_IDLE);

  ls_load_extend #(
    .OPNUM_W (OPNUM_W),
    .XLEN    (XLEN)
  ) u_load_extend (
    .i_opnum    (r_opnum),
    .i_raw_data (data_from_mc),
    .o_ext_data (w_ext_data)
  );

  // Main FSM: issue to memory, wait for finish, broadcast or discard load result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= ST_IDLE;
      r_opnum           <= '0;
      r_rob_id          <= '0;
      enable_sign_to_mc <= 1'b0;
      rw_flag_to_mc     <= 1'b0;
      address_to_mc     <= '0;
      length_to_mc      <= '0;
      store_data_to_mc  <= '0;
      valid_sign        <= 1'b0;
      rob_id            <= '0;
      data              <= '0;
    end else if (rdy) begin
      valid_sign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opnum           <= opnum_from_ls;
            r_rob_id          <= rob_id_from_ls;
            enable_sign_to_mc <= 1'b1;
            rw_flag_to_mc     <= w_req_store;
            address_to_mc     <= address_from_ls;
            length_to_mc      <= op_length(opnum_from_ls);
            store_data_to_mc  <= store_data_from_ls;
            r_state           <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (finish_sign_from_mc) begin
            enable_sign_to_mc <= 1'b0;
            r_state           <= ST_IDLE;
            // A rollback coinciding with finish kills the load broadcast
            if (!rw_flag_to_mc && !rollback_sign_from_rob) begin
              valid_sign <= 1'b1;
              rob_id     <= r_rob_id;
              data       <= w_ext_data;
            end
          end else if (rollback_sign_from_rob && !rw_flag_to_mc) begin
            // Memory read must still complete; just forget the result
            r_state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (finish_sign_from_mc) begin
            enable_sign_to_mc <= 1'b0;
            r_state           <= ST_IDLE;
          end
        end
        default: begin
          enable_sign_to_mc <= 1'b0;
          r_state           <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LS_EXECUTOR_PERF_EN
  // Count completed loads/stores and cycles spent waiting on memory
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_load_cnt  <= '0;
      perf_store_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (rdy) begin
      if (r_state != ST_IDLE) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
        if (finish_sign_from_mc) begin
          if (rw_flag_to_mc) begin
            perf_store_cnt <= perf_store_cnt + 32'd1;
          end else begin
            perf_load_cnt <= perf_load_cnt + 32'd1;
          end
        end
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // LS must never present a request while the executor is busy
  a_no_req_when_full: assert property (
    @(posedge clk) disable iff (!rst)
    !(rdy && enable_sign_from_ls && (r_state != ST_IDLE))
  );
`endif

endmodule

// File: doc/ls_executor.md
Name: ls_executor

Overview:
- Load/store execution unit directly downstream of the LS buffer in the Tomasulo RV32I core.
- Accepts one memory request at a time from LS: opcode, effective address, store data and ROB id.
- Drives the memory controller with a multi-cycle request/finish handshake.
- Sign/zero-extends load data and broadcasts load results (valid, rob_id, data) to the CDB, i.e. to ROB, RS and LS.

Parameters:
- OPNUM_W, 6, opcode field width; matches `OPNUM_TYPE.
- ROB_ID_W, 4, ROB tag width; matches `ROB_ID_TYPE.
- XLEN, 32, data and address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when low, all state and outputs hold.
- enable_sign_from_ls  in  1  request strobe, one cycle.
- opnum_from_ls  in  OPNUM_W  LB/LH/LW/LBU/LHU/SB/SH/SW.
- address_from_ls  in  XLEN  effective address.
- store_data_from_ls  in  XLEN  store data (low bytes used).
- rob_id_from_ls  in  ROB_ID_W  tag of the request.
- rollback_sign_from_rob  in  1  mispredict flush.
- full_sign_to_ls  out  1  busy; LS must not send a request while it is high.
- enable_sign_to_mc  out  1  memory request active.
- rw_flag_to_mc  out  1  0 = read, 1 = write.
- address_to_mc  out  XLEN  request address.
- length_to_mc  out  3  byte count: 1, 2 or 4.
- store_data_to_mc  out  XLEN  write data.
- finish_sign_from_mc  in  1  one-cycle completion pulse.
- data_from_mc  in  XLEN  raw read data, right-aligned.
- valid_sign  out  1  CDB broadcast valid.
- rob_id  out  ROB_ID_W  CDB tag.
- data  out  XLEN  CDB value.

Behaviour:
- States: IDLE, BUSY, DISCARD.
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0.
- full_sign_to_ls is combinational: 1 when state != IDLE.
- IDLE:
  - On enable (cycle N), latch the request.
  - In cycle N+1: enable_sign_to_mc=1, rw/address/length/store_data driven; go to BUSY.
  - length from opcode: B=1, H=2, W=4. Store data passes through unmasked; the controller uses the low `length` bytes.
- BUSY:
  - Hold all mc outputs stable until finish_sign_from_mc.
  - On finish in cycle M: drop enable_sign_to_mc in M+1 and return to IDLE.
  - Loads only: in M+1, valid_sign=1 for exactly one cycle, with rob_id=latched tag and data=extended value.
  - Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Stores produce no CDB broadcast.
  - A new request is accepted at M+1 at the earliest.
- Rollback:
  - Stores are never cancelled; they are post-commit.
  - Rollback while a load is in BUSY: go to DISCARD. Keep the mc request until finish, then go to IDLE with no valid_sign.
  - Rollback in the same cycle as a load enable: drop the load. A store enable in that cycle is accepted.
  - Rollback in the same cycle as finish for a load: suppress the broadcast.
  - Rollback clears a pending valid_sign.
- valid_sign defaults to 0 every cycle.
- rdy=0 freezes state, including a pending finish. The memory controller holds finish while rdy is low.
- Reset mid-transaction aborts immediately; the memory controller is reset by the same rst.
- A request while full is a protocol violation; it is ignored and flagged by an assertion in simulation.

Optional Feature:
- Macro: LS_EXECUTOR_PERF_EN.
- Defined:
  - Adds outputs perf_load_cnt, perf_store_cnt, perf_stall_cnt, each 32 bits.
  - Load and store counters increment on completion.
  - Stall counter increments every BUSY/DISCARD cycle with rdy=1.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: no ports, no logic.

Decomposition:
- Shared defines.v holds:
  - OPNUM codes `OPNUM_LB..`OPNUM_SW.
  - `OPNUM_TYPE, `ROB_ID_TYPE, `DATA_TYPE, `ADDR_TYPE.
  - State encodings.
  - Length constants LEN_B/H/W.
- One natural combinational sub-module, ls_load_extend: opcode + raw data -> extended data.

Test Plan:
- LW, addr 0x100, rob 3; mc finishes 3 cycles after request with 0x80FF1234 -> valid_sign for one cycle, data=0x80FF1234, rob_id=3; full low that same cycle.
- LB and LBU with raw 0x000000F0 -> data 0xFFFFFFF0 and 0x000000F0. LH with raw 0x00008001 -> 0xFFFF8001.
- SH, addr 0x20, data 0xDEADBEEF -> mc sees rw=1, length=2, data 0xDEADBEEF; no valid_sign; full drops after finish.
- LW in BUSY, rollback pulse, then finish 2 cycles later -> no valid_sign; full stays high until the cycle after finish.
- Rollback and SB enable in the same cycle -> store completes normally. Rollback and LW enable in the same cycle -> no mc request.
- Back-to-back: LW finishes, new SW enable in the cycle after finish -> accepted, and the mc request rises the next cycle. Assert rst low mid-BUSY -> all outputs 0 asynchronously.
